// File: rtl/parking_pkg.sv
// Shared types and helpers for the multi-gate parking lot counter.
package parking_pkg;

  localparam int GATES_MAX = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EN1  = 3'd1,
    EN2  = 3'd2,
    EN3  = 3'd3,
    EX1  = 3'd4,
    EX2  = 3'd5,
    EX3  = 3'd6
  } gate_state_t;

  function automatic logic [3:0] popcount(input logic [GATES_MAX-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < GATES_MAX; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/parking_gate_fsm.sv
// One gate's a/b sensor sequence detector with registered one-cycle
// entry/exit pulses.
module parking_gate_fsm
  import parking_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_a,
  input  logic i_b,
  output logic o_enter,
  output logic o_exit
);

  gate_state_t state_q, state_d;
  logic        enter_q, enter_d;
  logic        exit_q, exit_d;
  logic [1:0]  ab;

  assign ab = {i_a, i_b};

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    enter_d = 1'b0;
    exit_d  = 1'b0;
    unique case (state_q)
      IDLE: if (ab == 2'b10) state_d = EN1;
            else if (ab == 2'b01) state_d = EX1;
      EN1: case (ab)
        2'b11:   state_d = EN2;
        2'b10:   state_d = EN1;
        default: state_d = IDLE;
      endcase
      EN2: case (ab)
        2'b01: state_d = EN3;
        2'b10: state_d = EN1;
        2'b11: state_d = EN2;
        default: state_d = IDLE;
      endcase
      EN3: case (ab)
        2'b00: begin state_d = IDLE; enter_d = 1'b1; end
        2'b11: state_d = EN2;
        2'b01: state_d = EN3;
        default: state_d = IDLE;
      endcase
      EX1: case (ab)
        2'b11:   state_d = EX2;
        2'b01:   state_d = EX1;
        default: state_d = IDLE;
      endcase
      EX2: case (ab)
        2'b10: state_d = EX3;
        2'b01: state_d = EX1;
        2'b11: state_d = EX2;
        default: state_d = IDLE;
      endcase
      EX3: case (ab)
        2'b00: begin state_d = IDLE; exit_d = 1'b1; end
        2'b11: state_d = EX2;
        2'b10: state_d = EX3;
        default: state_d = IDLE;
      endcase
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      enter_q <= enter_d;
      exit_q  <= exit_d;
    end
  end

  assign o_enter = enter_q;
  assign o_exit  = exit_q;

endmodule

// File: rtl/parking_lot_multi_gate.sv
// Multi-gate parking lot occupancy counter: per-gate FSMs, netted saturating
// count and sticky error flags. Define PLMG_INPUT_SYNC_EN for 2-flop input sync.
module parking_lot_multi_gate
  import parking_pkg::*;
#(
  parameter int N_GATES  = 2,
  parameter int CAPACITY = 200,
  parameter int COUNT_W  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_GATES-1:0] i_a,
  input  logic [N_GATES-1:0] i_b,
  output logic [N_GATES-1:0] o_car_enter,
  output logic [N_GATES-1:0] o_car_exit,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_overflow,
  output logic               o_underflow
);

  localparam int               SUM_W = COUNT_W + 2;
  localparam logic [COUNT_W-1:0] CAP_C = COUNT_W'(CAPACITY);

  if (N_GATES < 1 || N_GATES > GATES_MAX) begin : g_bad_gates
    $error("N_GATES must be in 1..%0d", GATES_MAX);
  end
  if (CAPACITY < 1 || CAPACITY >= (1 << COUNT_W)) begin : g_bad_capacity
    $error("CAPACITY must be in 1..2**COUNT_W-1");
  end

  logic [N_GATES-1:0] a_s, b_s;

`ifdef PLMG_INPUT_SYNC_EN
  logic [N_GATES-1:0] a_meta_q, a_sync_q, b_meta_q, b_sync_q;

  // NOTE: synchronizer flops are reset so no stale sensor state leaks past reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_meta_q <= '0;
      a_sync_q <= '0;
      b_meta_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_meta_q <= i_a;
      a_sync_q <= a_meta_q;
      b_meta_q <= i_b;
      b_sync_q <= b_meta_q;
    end
  end

  assign a_s = a_sync_q;
  assign b_s = b_sync_q;
`else
  assign a_s = i_a;
  assign b_s = i_b;
`endif

  for (genvar g = 0; g < N_GATES; g++) begin : g_gate
    parking_gate_fsm u_fsm (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_a    (a_s[g]),
      .i_b    (b_s[g]),
      .o_enter(o_car_enter[g]),
      .o_exit (o_car_exit[g])
    );
  end

  logic [GATES_MAX-1:0]      enter_ext, exit_ext;
  logic [3:0]                e_cnt, x_cnt;
  logic signed [SUM_W-1:0]   sum;
  logic [COUNT_W-1:0]        count_q, count_d;
  logic                      ovf_q, ovf_d, unf_q, unf_d;

  // Signed sum is two bits wider than the count so both over- and underflow are visible.
  always_comb begin
    enter_ext                = '0;
    exit_ext                 = '0;
    enter_ext[N_GATES-1:0]   = o_car_enter;
    exit_ext[N_GATES-1:0]    = o_car_exit;
    e_cnt                    = popcount(enter_ext);
    x_cnt                    = popcount(exit_ext);
    sum                      = SUM_W'(count_q) + SUM_W'(e_cnt) - SUM_W'(x_cnt);
    count_d                  = count_q;
    ovf_d                    = ovf_q;
    unf_d                    = unf_q;
    if (sum[SUM_W-1]) begin
      count_d = '0;
      unf_d   = 1'b1;
    end else if (sum[SUM_W-2:0] > (SUM_W-1)'(CAPACITY)) begin
      count_d = CAP_C;
      ovf_d   = 1'b1;
    end else begin
      count_d = sum[COUNT_W-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign o_count     = count_q;
  assign o_full      = (count_q == CAP_C);
  assign o_empty     = (count_q == '0);
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule

// File: tb/tb_parking_lot_multi_gate.sv
// Directed bench: a 200-capacity lot and a 3-capacity lot share all stimulus.
module tb_parking_lot_multi_gate;

`ifdef PLMG_INPUT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  a = '0, b = '0;
  logic [1:0]  ent, ext, ent3, ext3;
  logic [15:0] cnt, cnt3;
  logic        full, empty, ovf, unf, full3, empty3, ovf3, unf3;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  parking_lot_multi_gate #(.N_GATES(2), .CAPACITY(200), .COUNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_a(a), .i_b(b),
    .o_car_enter(ent), .o_car_exit(ext), .o_count(cnt),
    .o_full(full), .o_empty(empty), .o_overflow(ovf), .o_underflow(unf)
  );

  parking_lot_multi_gate #(.N_GATES(2), .CAPACITY(3), .COUNT_W(16)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_a(a), .i_b(b),
    .o_car_enter(ent3), .o_car_exit(ext3), .o_count(cnt3),
    .o_full(full3), .o_empty(empty3), .o_overflow(ovf3), .o_underflow(unf3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] av, input logic [1:0] bv, input int n);
    a = av;
    b = bv;
    repeat (n) tick();
  endtask

  // Gate 0 entry: ab 10,11,01 then 00 held n00 cycles.
  task automatic entry0(input int n00);
    drive(2'b01, 2'b00, 3);
    drive(2'b01, 2'b01, 3);
    drive(2'b00, 2'b01, 3);
    drive(2'b00, 2'b00, n00);
  endtask

  // Gate 0 exit: ab 01,11,10 then 00.
  task automatic exit0(input int n00);
    drive(2'b00, 2'b01, 3);
    drive(2'b01, 2'b01, 3);
    drive(2'b01, 2'b00, 3);
    drive(2'b00, 2'b00, n00);
  endtask

  // Gate 0 entry and gate 1 exit, step-aligned.
  task automatic simul(input int n00);
    drive(2'b01, 2'b10, 3);
    drive(2'b11, 2'b11, 3);
    drive(2'b10, 2'b01, 3);
    drive(2'b00, 2'b00, n00);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_count", 32'(cnt), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_unf", 32'(unf), 0);
    check("rst_enter", 32'(ent), 0);
    check("rst_exit", 32'(ext), 0);
    rst = 1'b0;
    tick();

    // Single entry on gate 0 with exact pulse timing
    entry0(1);
    for (int i = 0; i < SYNC_LAT; i++) begin
      check("ent_early", 32'(ent), 0);
      tick();
    end
    check("ent_pulse", 32'(ent), 32'h1);
    check("ent_noexit", 32'(ext), 0);
    check("ent_cnt_before", 32'(cnt), 0);
    tick();
    check("ent_pulse_end", 32'(ent), 0);
    check("ent_cnt_after", 32'(cnt), 1);
    check("ent_not_empty", 32'(empty), 0);

    // Gate 1 backs out: 10,11,10,00
    drive(2'b10, 2'b00, 3);
    drive(2'b10, 2'b10, 3);
    drive(2'b10, 2'b00, 3);
    a = 2'b00;
    b = 2'b00;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("backout_enter", 32'(ent), 0);
      check("backout_exit", 32'(ext), 0);
    end
    check("backout_cnt", 32'(cnt), 1);

    // Fill to 5 then net an entry against an exit
    repeat (4) entry0(3 + SYNC_LAT);
    check("cnt5", 32'(cnt), 5);
    simul(1);
    repeat (SYNC_LAT) tick();
    check("net_enter", 32'(ent), 32'h1);
    check("net_exit", 32'(ext), 32'h2);
    tick();
    check("net_cnt", 32'(cnt), 5);
    check("net_ovf", 32'(ovf), 0);
    check("net_unf", 32'(unf), 0);

    // Capacity-3 lot: fill, net at full, then overflow
    pulse_reset();
    check("cap3_rst_cnt", 32'(cnt3), 0);
    check("cap3_rst_ovf", 32'(ovf3), 0);
    repeat (3) entry0(3 + SYNC_LAT);
    check("cap3_cnt3", 32'(cnt3), 3);
    check("cap3_full", 32'(full3), 1);
    check("cap3_noovf", 32'(ovf3), 0);
    simul(3 + SYNC_LAT);
    check("cap3_net_cnt", 32'(cnt3), 3);
    check("cap3_net_noovf", 32'(ovf3), 0);
    check("cap3_net_main", 32'(cnt), 3);
    entry0(3 + SYNC_LAT);
    check("cap3_sat_cnt", 32'(cnt3), 3);
    check("cap3_sat_full", 32'(full3), 1);
    check("cap3_ovf", 32'(ovf3), 1);
    check("main_cnt4", 32'(cnt), 4);
    check("main_full_no", 32'(full), 0);
    drive(2'b00, 2'b00, 5);
    check("cap3_ovf_sticky", 32'(ovf3), 1);

    // Empty lot: netting leaves no flag, then a lone exit underflows
    pulse_reset();
    check("ovf_cleared", 32'(ovf3), 0);
    simul(3 + SYNC_LAT);
    check("empty_net_cnt", 32'(cnt), 0);
    check("empty_net_unf", 32'(unf), 0);
    exit0(3 + SYNC_LAT);
    check("unf_cnt", 32'(cnt), 0);
    check("unf_flag", 32'(unf), 1);
    check("unf_empty", 32'(empty), 1);
    drive(2'b00, 2'b00, 4);
    check("unf_sticky", 32'(unf), 1);

    // Reset while gate 0 sits in EN2; remaining 01,00 must not count
    pulse_reset();
    drive(2'b01, 2'b00, 3);
    drive(2'b01, 2'b01, 3);
    pulse_reset();
    drive(2'b01, 2'b01, 2);
    drive(2'b00, 2'b01, 3);
    a = 2'b00;
    b = 2'b00;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_enter", 32'(ent), 0);
      check("midrst_exit", 32'(ext), 0);
    end
    check("midrst_cnt", 32'(cnt), 0);
    check("midrst_unf", 32'(unf), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
